image_window_reader: RTL and testbench

- Reads the 28x28 8-bit image from the four image RAM banks that the host load path fills.
- Emits every 3x3 valid-convolution window (26x26 = 676 windows, stride 1) to the conv engine over a valid/ready stream, in raster order.
- Sits directly downstream of the image-bank write stage and upstream of the conv MAC array.

---
 rtl/image_window_reader_if.sv | 35 +++
 rtl/image_window_reader.sv | 147 ++++++++++++++
 tb/tb_image_window_reader.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/image_window_reader_if.sv
// Image-bank read bus and 3x3 window stream between the reader and its neighbours.
// master = reader side; slave = RAM banks / conv engine side.
interface image_window_reader_if #(
  parameter int ADDR_W = 10
);
  logic              img_rden;
  logic [ADDR_W-1:0] img_addr0;
  logic [ADDR_W-1:0] img_addr1;
  logic [ADDR_W-1:0] img_addr2;
  logic [ADDR_W-1:0] img_addr3;
  logic [7:0]        img_q0;
  logic [7:0]        img_q1;
  logic [7:0]        img_q2;
  logic [7:0]        img_q3;
  logic              win_valid;
  logic              win_ready;
  logic [71:0]       win_data;
  logic [4:0]        win_row;
  logic [4:0]        win_col;
  logic              win_last;

  modport master (
    output img_rden, img_addr0, img_addr1, img_addr2, img_addr3,
    input  img_q0, img_q1, img_q2, img_q3,
    output win_valid, win_data, win_row, win_col, win_last,
    input  win_ready
  );

  modport slave (
    input  img_rden, img_addr0, img_addr1, img_addr2, img_addr3,
    output img_q0, img_q1, img_q2, img_q3,
    input  win_valid, win_data, win_row, win_col, win_last,
    output win_ready
  );
endinterface

// File: rtl/image_window_reader.sv
// Walks the 28x28 image held in four column-interleaved RAM banks and streams
// every 3x3 valid-convolution window in raster order over a valid/ready port.
module image_window_reader #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 3,
  parameter int ADDR_W = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
  image_window_reader_if.master bus
);
  localparam int WORDS = IMG_W / 4;
  localparam int OUT_W = IMG_W - K + 1;
  localparam int OUT_H = IMG_H - K + 1;

  typedef enum logic [2:0] {IDLE, F0, F1, F2, F3, OUT} state_t;

  state_t            state_q, state_d;
  logic [4:0]        row_q, row_d, col_q, col_d;
  logic [71:0]       win_q, win_d;
  logic              done_d;
  logic              fetch_en, cap_en;
  logic [4:0]        fetch_row;
  int unsigned       cap_slot;
  logic [4:0]        cc;
  logic [7:0]        q    [4];
  logic [ADDR_W-1:0] addr [4];
  logic              last;

  assign q[0] = bus.img_q0;
  assign q[1] = bus.img_q1;
  assign q[2] = bus.img_q2;
  assign q[3] = bus.img_q3;

  assign last = (row_q == 5'(OUT_H - 1)) && (col_q == 5'(OUT_W - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      win_q   <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      win_q   <= win_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    win_d     = win_q;
    done_d    = 1'b0;
    fetch_en  = 1'b0;
    fetch_row = '0;
    cap_en    = 1'b0;
    cap_slot  = 0;
    cc        = '0;
    for (int unsigned b = 0; b < 4; b++) addr[b] = '0;

    unique case (state_q)
      IDLE: begin
        row_d = '0;
        col_d = '0;
        // done is still high in the first IDLE cycle, which masks a coincident start
        if (start && !done) state_d = F0;
      end
      F0: begin
        fetch_en  = 1'b1;
        fetch_row = row_q;
        state_d   = F1;
      end
      F1: begin
        fetch_en  = 1'b1;
        fetch_row = row_q + 5'd1;
        cap_en    = 1'b1;
        cap_slot  = 0;
        state_d   = F2;
      end
      F2: begin
        fetch_en  = 1'b1;
        fetch_row = row_q + 5'd2;
        cap_en    = 1'b1;
        cap_slot  = 1;
        state_d   = F3;
      end
      F3: begin
        cap_en   = 1'b1;
        cap_slot = 2;
        state_d  = OUT;
      end
      OUT: begin
        if (bus.win_ready) begin
          if (last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = F0;
            if (col_q == 5'(OUT_W - 1)) begin
              col_d = '0;
              row_d = row_q + 5'd1;
            end else begin
              col_d = col_q + 5'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Column c+j lives in bank (c+j) mod 4; the one bank not touched keeps address 0.
    if (fetch_en) begin
      for (int unsigned j = 0; j < 3; j++) begin
        cc = col_q + 5'(j);
        addr[cc[1:0]] = ADDR_W'(fetch_row) * ADDR_W'(WORDS) + ADDR_W'(cc[4:2]);
      end
    end

    if (cap_en) begin
      for (int unsigned j = 0; j < 3; j++) begin
        cc = col_q + 5'(j);
        win_d[71 - 8 * (3 * cap_slot + j) -: 8] = q[cc[1:0]];
      end
    end
  end

  assign bus.img_rden  = fetch_en;
  assign bus.img_addr0 = addr[0];
  assign bus.img_addr1 = addr[1];
  assign bus.img_addr2 = addr[2];
  assign bus.img_addr3 = addr[3];
  assign bus.win_valid = (state_q == OUT);
  assign bus.win_data  = win_q;
  assign bus.win_row   = row_q;
  assign bus.win_col   = col_q;
  assign bus.win_last  = (state_q == OUT) && last;
  assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_image_window_reader.sv
// Bench for image_window_reader: bank RAM model, golden window list from the
// image array, directed corner cases and randomized backpressure passes.
module tb_image_window_reader;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic busy, done;
  int   errors = 0;
  int   checks = 0;

  image_window_reader_if #(.ADDR_W(10)) bus ();

  image_window_reader #(
    .IMG_W (28),
    .IMG_H (28),
    .K     (3),
    .ADDR_W(10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .busy (busy),
    .done (done),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] img [28][28];
  logic [7:0] mem [4][196];
  logic [9:0] max_addr = '0;
  logic [126:0] all_out;

  assign all_out = {busy, done, bus.img_rden, bus.img_addr0, bus.img_addr1, bus.img_addr2,
                    bus.img_addr3, bus.win_valid, bus.win_data, bus.win_row, bus.win_col,
                    bus.win_last};

  function automatic logic [7:0] rd(int b, logic [9:0] a);
    return (a <= 10'd195) ? mem[b][a[7:0]] : 8'h00;
  endfunction

  // Synchronous RAM banks, one-cycle read latency
  always @(posedge clk) begin
    if (bus.img_rden) begin
      bus.img_q0 <= rd(0, bus.img_addr0);
      bus.img_q1 <= rd(1, bus.img_addr1);
      bus.img_q2 <= rd(2, bus.img_addr2);
      bus.img_q3 <= rd(3, bus.img_addr3);
      if (bus.img_addr0 > max_addr) max_addr <= bus.img_addr0;
      if (bus.img_addr1 > max_addr) max_addr <= bus.img_addr1;
      if (bus.img_addr2 > max_addr) max_addr <= bus.img_addr2;
      if (bus.img_addr3 > max_addr) max_addr <= bus.img_addr3;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_image(input bit ramp);
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++) begin
        img[r][c] = ramp ? 8'((r * 28 + c) % 256) : 8'($urandom_range(0, 255));
        mem[c % 4][r * 7 + c / 4] = img[r][c];
      end
  endtask

  function automatic logic [71:0] gold(int k);
    logic [71:0] d;
    int r, c;
    r = k / 26;
    c = k % 26;
    d = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        d[71 - 8 * (3 * i + j) -: 8] = img[r + i][c + j];
    return d;
  endfunction

  task automatic pulse_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    bus.win_ready = 1'b0;
    step();
    step();
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0", all_out);
    end
    reset = 1'b1;
    step();
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL idle_after_release got=%h exp=0", all_out);
    end
  endtask

  task automatic test_first_window();
    int n;
    logic [71:0] exp_d;
    exp_d = {8'd0, 8'd1, 8'd2, 8'd28, 8'd29, 8'd30, 8'd56, 8'd57, 8'd58};
    load_image(1'b1);
    bus.win_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    while (!bus.win_valid && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (n !== 5) begin
      errors++;
      $display("FAIL first_latency got=%0d exp=5", n);
    end
    checks++;
    if ({bus.win_row, bus.win_col} !== 10'd0) begin
      errors++;
      $display("FAIL first_rowcol got=%0d,%0d exp=0,0", bus.win_row, bus.win_col);
    end
    checks++;
    if (bus.win_data !== exp_d) begin
      errors++;
      $display("FAIL first_data got=%h exp=%h", bus.win_data, exp_d);
    end
    checks++;
    if (busy !== 1'b1 || bus.win_last !== 1'b0) begin
      errors++;
      $display("FAIL first_busy_last got=%b%b exp=10", busy, bus.win_last);
    end
    pulse_reset();
  endtask

  task automatic test_word_cross();
    int n;
    logic [71:0] exp_d;
    exp_d = {8'd2, 8'd3, 8'd4, 8'd30, 8'd31, 8'd32, 8'd58, 8'd59, 8'd60};
    load_image(1'b1);
    bus.win_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!(bus.win_valid && bus.win_row == 5'd0 && bus.win_col == 5'd1) && n < 100) begin
      step();
      n++;
    end
    step();
    checks++;
    if ({bus.img_rden, bus.img_addr0, bus.img_addr1, bus.img_addr2, bus.img_addr3} !==
        {1'b1, 10'd1, 10'd0, 10'd0, 10'd0}) begin
      errors++;
      $display("FAIL cross_addr got=%b a0=%0d a1=%0d a2=%0d a3=%0d exp=1 1 0 0 0",
               bus.img_rden, bus.img_addr0, bus.img_addr1, bus.img_addr2, bus.img_addr3);
    end
    bus.win_ready = 1'b0;
    n = 0;
    while (!bus.win_valid && n < 20) begin
      step();
      n++;
    end
    checks++;
    if ({bus.win_row, bus.win_col, bus.win_data} !== {5'd0, 5'd2, exp_d}) begin
      errors++;
      $display("FAIL cross_window got=%0d,%0d %h exp=0,2 %h",
               bus.win_row, bus.win_col, bus.win_data, exp_d);
    end
    pulse_reset();
  endtask

  // One full pass with randomized consumer; scoreboards against the golden list.
  task automatic run_pass(input int ready_pct, input bit noise, input bit timing, input bit ramp);
    int n, idx, first_n;
    bit held, bad_idle;
    logic [82:0] hold_v, got, exp_v;
    logic [71:0] last_d;
    last_d = {8'd213, 8'd214, 8'd215, 8'd241, 8'd242, 8'd243, 8'd13, 8'd14, 8'd15};
    idx = 0;
    first_n = -1;
    held = 1'b0;
    hold_v = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    while (!done && n < 20000) begin
      got = {bus.win_row, bus.win_col, bus.win_last, bus.win_data};
      if (held) begin
        checks++;
        if (!bus.win_valid || got !== hold_v) begin
          errors++;
          $display("FAIL stall_stable got=%b %h exp=1 %h", bus.win_valid, got, hold_v);
        end
      end
      held = 1'b0;
      if (bus.win_valid) begin
        if (first_n < 0) first_n = n;
        bus.win_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
        if (bus.win_ready) begin
          exp_v = {5'(idx / 26), 5'(idx % 26), (idx == 675), gold(idx)};
          checks++;
          if (idx > 675 || got !== exp_v) begin
            errors++;
            $display("FAIL window_%0d got=%h exp=%h", idx, got, exp_v);
          end
          if (ramp && idx == 675) begin
            checks++;
            if (bus.win_data !== last_d) begin
              errors++;
              $display("FAIL last_data got=%h exp=%h", bus.win_data, last_d);
            end
          end
          idx++;
        end else begin
          held = 1'b1;
          hold_v = got;
        end
      end else begin
        bus.win_ready = 1'($urandom_range(0, 1));
      end
      start = noise && busy && ($urandom_range(0, 7) == 0);
      step();
      start = 1'b0;
      n++;
      if (!done) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_in_pass cycle=%0d got=%b exp=1", n, busy);
        end
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || idx !== 676) begin
      errors++;
      $display("FAIL pass_end done=%b busy=%b windows=%0d exp=1 0 676", done, busy, idx);
    end
    if (timing) begin
      checks++;
      if (first_n !== 5 || n !== 3381) begin
        errors++;
        $display("FAIL pass_timing first=%0d done_at=%0d exp=5 3381", first_n, n);
      end
    end
    start = 1'b1;
    step();
    start = 1'b0;
    bad_idle = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy || done || bus.win_valid || bus.img_rden) bad_idle = 1'b1;
      step();
    end
    checks++;
    if (bad_idle !== 1'b0) begin
      errors++;
      $display("FAIL after_done got=%b exp=0", bad_idle);
    end
  endtask

  task automatic test_full_pass();
    load_image(1'b1);
    run_pass(100, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_backpressure();
    load_image(1'b0);
    run_pass(55, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midpass();
    int n;
    load_image(1'b0);
    bus.win_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!(bus.win_valid && bus.win_row == 5'd10 && bus.win_col == 5'd7) && n < 5000) begin
      step();
      n++;
    end
    checks++;
    if (n >= 5000) begin
      errors++;
      $display("FAIL midpass_reach got=%0d exp<5000", n);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL midpass_reset got=%h exp=0", all_out);
    end
    step();
    step();
    reset = 1'b1;
    step();
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL midpass_no_done got=%h exp=0", all_out);
    end
    run_pass(70, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_addr_range();
    checks++;
    if (max_addr !== 10'd195) begin
      errors++;
      $display("FAIL max_addr got=%0d exp=195", max_addr);
    end
  endtask

  initial begin
    bus.win_ready = 1'b0;
    bus.img_q0 = '0;
    bus.img_q1 = '0;
    bus.img_q2 = '0;
    bus.img_q3 = '0;
    load_image(1'b1);
    test_reset();
    test_first_window();
    test_word_cross();
    test_full_pass();
    test_backpressure();
    test_reset_midpass();
    test_addr_range();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
